sram_rw_port_arbiter: RTL and testbench

Controller for the RW port (port 0) of the 32x256 1rw1r SRAM macro. It zeroes the whole array after reset, then shares port 0 between two requesters with round-robin arbitration, valid/ready request handshakes and fixed-latency responses. Requester A is the core load/store path and requester B is the host/debug path. The read-only port 1 is outside this block and is wired directly by its user.

---
 rtl/sram_arb_pkg.sv | 11 +
 rtl/rr_arb2.sv | 32 +++
 rtl/sram_rw_port_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_rw_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM port-0 arbiter.
package sram_arb_pkg;

    typedef enum logic {StInit, StRun} state_e;
    typedef enum logic {GrantA, GrantB} grant_e;

    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefNumWmasks = DefDataWidth / 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_l,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] rdy,
    output logic [1:0] gnt
);

    grant_e last_q;

    // Readiness looks only at the other requester, never at the requester's own valid.
    always_comb begin
        rdy[0] = !req[1] || (last_q == GrantB);
        rdy[1] = !req[0] || (last_q == GrantA);
        gnt    = req & rdy;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            last_q <= GrantB;
        end else if (accept && gnt[0]) begin
            last_q <= GrantA;
        end else if (accept && gnt[1]) begin
            last_q <= GrantB;
        end
    end

endmodule

// File: rtl/sram_rw_port_arbiter.sv
// RW-port controller for the 1rw1r SRAM: scrubs the array after reset, then
// shares port 0 between requesters A and B with 1-cycle fixed-latency responses.
module sram_rw_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned NUM_WMASKS = DefNumWmasks
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [NUM_WMASKS-1:0] a_req_wmask,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [NUM_WMASKS-1:0] b_req_wmask,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] scrub_cnt_q;
    logic                  init_done_q;
    logic                  a_rsp_q, b_rsp_q, rsp_is_read_q;
    logic [1:0]            arb_rdy, arb_gnt;
    logic                  run, a_acc, b_acc;

    assign run = (state_q == StRun);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_l  (rst_l),
        .req    ({b_req_valid, a_req_valid}),
        .accept (run),
        .rdy    (arb_rdy),
        .gnt    (arb_gnt)
    );

    assign a_req_ready = run && arb_rdy[0];
    assign b_req_ready = run && arb_rdy[1];
    assign a_acc       = run && arb_gnt[0];
    assign b_acc       = run && arb_gnt[1];
    assign init_done   = init_done_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= StInit;
            scrub_cnt_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    scrub_cnt_q <= scrub_cnt_q + ADDR_WIDTH'(1);
                    if (scrub_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end
                end
                StRun:   state_q <= StRun;
                default: state_q <= StInit;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            a_rsp_q       <= 1'b0;
            b_rsp_q       <= 1'b0;
            rsp_is_read_q <= 1'b0;
        end else begin
            a_rsp_q       <= a_acc;
            b_rsp_q       <= b_acc;
            rsp_is_read_q <= a_acc ? !a_req_we : !b_req_we;
        end
    end

    assign a_rsp_valid = a_rsp_q;
    assign b_rsp_valid = b_rsp_q;
    assign a_rsp_rdata = (a_rsp_q && rsp_is_read_q) ? sram_dout0 : '0;
    assign b_rsp_rdata = (b_rsp_q && rsp_is_read_q) ? sram_dout0 : '0;

    // Reset overrides the INIT drive so the macro sees an idle port while rst_l is low.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (rst_l) begin
            if (!run) begin
                sram_csb0   = 1'b0;
                sram_web0   = 1'b0;
                sram_wmask0 = '1;
                sram_addr0  = scrub_cnt_q;
            end else if (a_acc) begin
                sram_csb0   = 1'b0;
                sram_web0   = !a_req_we;
                sram_wmask0 = a_req_wmask;
                sram_addr0  = a_req_addr;
                sram_din0   = a_req_wdata;
            end else if (b_acc) begin
                sram_csb0   = 1'b0;
                sram_web0   = !b_req_we;
                sram_wmask0 = b_req_wmask;
                sram_addr0  = b_req_addr;
                sram_din0   = b_req_wdata;
            end else begin
                sram_web0 = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Bench for sram_rw_port_arbiter with a behavioural 32x256 SRAM port-0 model.
module tb_sram_rw_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
    logic [3:0]  a_req_wmask;
    logic [7:0]  a_req_addr;
    logic [31:0] a_req_wdata, a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
    logic [3:0]  b_req_wmask;
    logic [7:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_rdata;
    logic        init_done, sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0, sram_dout0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_rw_port_arbiter dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_we    (a_req_we),
        .a_req_wmask (a_req_wmask),
        .a_req_addr  (a_req_addr),
        .a_req_wdata (a_req_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_rdata (a_rsp_rdata),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_we    (b_req_we),
        .b_req_wmask (b_req_wmask),
        .b_req_addr  (b_req_addr),
        .b_req_wdata (b_req_wdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_rdata (b_rsp_rdata),
        .init_done   (init_done),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    // SRAM model: inputs latched on posedge, array access on the following negedge.
    logic [31:0] mem [256];
    logic        csb_r = 1'b1, web_r = 1'b1;
    logic [3:0]  wmask_r;
    logic [7:0]  addr_r;
    logic [31:0] din_r;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hBAD0_0000 | i;
        sram_dout0 = 32'h0;
    end

    always @(posedge clk) begin
        csb_r   <= sram_csb0;
        web_r   <= sram_web0;
        wmask_r <= sram_wmask0;
        addr_r  <= sram_addr0;
        din_r   <= sram_din0;
    end

    always @(negedge clk) begin
        if (!csb_r && !web_r) begin
            for (int j = 0; j < 4; j++)
                if (wmask_r[j]) mem[addr_r][j*8 +: 8] <= din_r[j*8 +: 8];
        end
        if (!csb_r && web_r) sram_dout0 <= mem[addr_r];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  a_vw;   // {valid, we}
        logic [7:0]  a_addr;
        logic [31:0] a_data;
        logic [3:0]  a_mask;
        logic [1:0]  b_vw;
        logic [7:0]  b_addr;
        logic [31:0] b_data;
        logic [3:0]  b_mask;
        logic [4:0]  flags;  // {a_ready, b_ready, csb0, a_rsp_valid, b_rsp_valid}
        logic [31:0] rdata;  // data on whichever rsp_valid is expected high
    } vec_t;

    function automatic vec_t v(input logic [1:0] avw, input logic [7:0] aa,
                               input logic [31:0] ad, input logic [3:0] am,
                               input logic [1:0] bvw, input logic [7:0] ba,
                               input logic [31:0] bd, input logic [3:0] bm,
                               input logic [4:0] fl, input logic [31:0] rd);
        vec_t r;
        r.a_vw = avw; r.a_addr = aa; r.a_data = ad; r.a_mask = am;
        r.b_vw = bvw; r.b_addr = ba; r.b_data = bd; r.b_mask = bm;
        r.flags = fl; r.rdata = rd;
        return r;
    endfunction

    task automatic drive_idle();
        a_req_valid = 0; a_req_we = 0; a_req_wmask = 0; a_req_addr = 0; a_req_wdata = 0;
        b_req_valid = 0; b_req_we = 0; b_req_wmask = 0; b_req_addr = 0; b_req_wdata = 0;
    endtask

    // Entered at posedge+1 of the first cycle after rst_l rises; leaves at posedge+1 of cycle 257.
    task automatic run_init(input string tag);
        for (int k = 0; k < 256; k++) begin
            #6;
            chk($sformatf("%s scrub cycle %0d {csb,web,wmask,addr,din,init_done}", tag, k),
                {17'h0, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, init_done},
                {17'h0, 1'b0, 1'b0, 4'hF, 8'(k), 32'h0, 1'b0});
            if (k == 0 || k == 255)
                chk($sformatf("%s scrub cycle %0d readies", tag, k),
                    {a_req_ready, b_req_ready}, 2'b00);
            @(posedge clk); #1;
        end
        #6;
        chk({tag, " init_done at cycle 256"}, init_done, 1'b1);
        chk({tag, " csb idle at cycle 256"}, sram_csb0, 1'b1);
        @(posedge clk); #1;
    endtask

    vec_t vecs[21];

    initial begin
        vecs[0]  = v(2'b10, 8'hFF, 32'h0,        4'h0, 2'b00, 8'h00, 32'h0, 4'h0, 5'b10000, 32'h0);
        vecs[1]  = v(2'b11, 8'h10, 32'hDEADBEEF, 4'hF, 2'b00, 8'h00, 32'h0, 4'h0, 5'b11010, 32'h0);
        vecs[2]  = v(2'b10, 8'h10, 32'h0,        4'h0, 2'b00, 8'h00, 32'h0, 4'h0, 5'b11010, 32'h0);
        vecs[3]  = v(2'b11, 8'h20, 32'hAABBCCDD, 4'h5, 2'b00, 8'h00, 32'h0, 4'h0, 5'b11010,
                     32'hDEADBEEF);
        vecs[4]  = v(2'b10, 8'h20, 32'h0,        4'h0, 2'b00, 8'h00, 32'h0, 4'h0, 5'b11010, 32'h0);
        vecs[5]  = v(2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 8'h00, 32'h0, 4'h0, 5'b11110,
                     32'h00BB00DD);
        vecs[6]  = v(2'b00, 8'h00, 32'h0, 4'h0, 2'b11, 8'h01, 32'h11111111, 4'hF, 5'b01000, 32'h0);
        vecs[7]  = v(2'b00, 8'h00, 32'h0, 4'h0, 2'b11, 8'h02, 32'h22222222, 4'hF, 5'b11001, 32'h0);
        vecs[8]  = v(2'b00, 8'h00, 32'h0, 4'h0, 2'b11, 8'h03, 32'h33333333, 4'hF, 5'b11001, 32'h0);
        vecs[9]  = v(2'b00, 8'h00, 32'h0, 4'h0, 2'b11, 8'h04, 32'h44444444, 4'hF, 5'b11001, 32'h0);
        vecs[10] = v(2'b10, 8'h01, 32'h0, 4'h0, 2'b10, 8'h02, 32'h0, 4'h0, 5'b10001, 32'h0);
        vecs[11] = v(2'b10, 8'h01, 32'h0, 4'h0, 2'b10, 8'h02, 32'h0, 4'h0, 5'b01010, 32'h11111111);
        vecs[12] = v(2'b10, 8'h01, 32'h0, 4'h0, 2'b10, 8'h02, 32'h0, 4'h0, 5'b10001, 32'h22222222);
        vecs[13] = v(2'b10, 8'h01, 32'h0, 4'h0, 2'b10, 8'h02, 32'h0, 4'h0, 5'b01010, 32'h11111111);
        vecs[14] = v(2'b10, 8'h01, 32'h0, 4'h0, 2'b10, 8'h02, 32'h0, 4'h0, 5'b10001, 32'h22222222);
        vecs[15] = v(2'b10, 8'h01, 32'h0, 4'h0, 2'b10, 8'h02, 32'h0, 4'h0, 5'b01010, 32'h11111111);
        vecs[16] = v(2'b00, 8'h00, 32'h0, 4'h0, 2'b00, 8'h00, 32'h0, 4'h0, 5'b11101, 32'h22222222);
        vecs[17] = v(2'b11, 8'h30, 32'hCAFEF00D, 4'hF, 2'b00, 8'h00, 32'h0, 4'h0, 5'b10000, 32'h0);
        vecs[18] = v(2'b00, 8'h00, 32'h0, 4'h0, 2'b10, 8'h30, 32'h0, 4'h0, 5'b01010, 32'h0);
        vecs[19] = v(2'b00, 8'h00, 32'h0, 4'h0, 2'b00, 8'h00, 32'h0, 4'h0, 5'b11101, 32'hCAFEF00D);
        vecs[20] = v(2'b00, 8'h00, 32'h0, 4'h0, 2'b00, 8'h00, 32'h0, 4'h0, 5'b11100, 32'h0);

        drive_idle();
        rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1; #6;
        chk("reset {a_rdy,b_rdy,a_rsp,b_rsp,init_done}",
            {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, init_done}, 5'b0);
        chk("reset rsp_rdata", {a_rsp_rdata, b_rsp_rdata}, 64'h0);
        chk("reset sram {csb,web,wmask,addr,din}",
            {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
            {1'b1, 1'b1, 4'h0, 8'h0, 32'h0});
        @(posedge clk); #1;
        rst_l = 1'b1;
        run_init("first");

        for (int i = 0; i < 21; i++) begin
            {a_req_valid, a_req_we} = vecs[i].a_vw;
            a_req_addr = vecs[i].a_addr; a_req_wdata = vecs[i].a_data;
            a_req_wmask = vecs[i].a_mask;
            {b_req_valid, b_req_we} = vecs[i].b_vw;
            b_req_addr = vecs[i].b_addr; b_req_wdata = vecs[i].b_data;
            b_req_wmask = vecs[i].b_mask;
            #6;
            chk($sformatf("row %0d a_req_ready", i), a_req_ready, vecs[i].flags[4]);
            chk($sformatf("row %0d b_req_ready", i), b_req_ready, vecs[i].flags[3]);
            chk($sformatf("row %0d sram_csb0", i), sram_csb0, vecs[i].flags[2]);
            chk($sformatf("row %0d a_rsp_valid", i), a_rsp_valid, vecs[i].flags[1]);
            chk($sformatf("row %0d b_rsp_valid", i), b_rsp_valid, vecs[i].flags[0]);
            chk($sformatf("row %0d a_rsp_rdata", i), a_rsp_rdata,
                vecs[i].flags[1] ? vecs[i].rdata : 32'h0);
            chk($sformatf("row %0d b_rsp_rdata", i), b_rsp_rdata,
                vecs[i].flags[0] ? vecs[i].rdata : 32'h0);
            @(posedge clk); #1;
        end

        // Reset in the cycle after an accepted read drops the response.
        a_req_valid = 1; a_req_we = 0; a_req_addr = 8'h01;
        #6;
        chk("pre-reset read a_req_ready", a_req_ready, 1'b1);
        @(posedge clk); #1;
        drive_idle();
        rst_l = 1'b0;
        #6;
        chk("mid-reset a_rsp_valid", a_rsp_valid, 1'b0);
        chk("mid-reset a_rsp_rdata", a_rsp_rdata, 32'h0);
        chk("mid-reset init_done", init_done, 1'b0);
        chk("mid-reset {csb,web}", {sram_csb0, sram_web0}, 2'b11);
        @(posedge clk); #1; #6;
        chk("mid-reset a_rsp_valid later", a_rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst_l = 1'b1;
        run_init("second");

        a_req_valid = 1; a_req_we = 0; a_req_addr = 8'h10;
        #6;
        chk("post-rescrub read ready", a_req_ready, 1'b1);
        @(posedge clk); #1;
        drive_idle();
        #6;
        chk("post-rescrub a_rsp_valid", a_rsp_valid, 1'b1);
        chk("post-rescrub 0x10 rdata", a_rsp_rdata, 32'h0);
        @(posedge clk); #1; #6;
        chk("post-rescrub rsp pulse ends", a_rsp_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
